// File: rtl/multicycle_sequencer.sv
// Multi-cycle instruction sequencer: fetch / decode / execute / memory / write-back
// control for a small datapath, with memory wait timeout and HALT/ERROR trap states.
//
// state  | meaning
// IDLE   | waiting for start, all outputs low
// FETCH  | requesting instruction word, waits for imem_ready
// DECODE | opcode captured, legal/halt/illegal dispatch
// EXEC   | ALU cycle; branches and jumps complete here
// MEM    | data access held until dmem_ready or timeout
// WB     | register write-back, instruction retires
// HALT   | stopped by HALT opcode, exits only on reset
// ERROR  | illegal opcode or memory timeout, exits only on reset
module multicycle_sequencer #(
  parameter int                  PC_WIDTH    = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter int                  MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [19:0]         instr,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  input  logic                zero,
  output logic [PC_WIDTH-1:0] pc,
  output logic                imem_req,
  output logic                ir_load,
  output logic                regdst,
  output logic                alusrc,
  output logic                regwrite,
  output logic                memread,
  output logic                memwrite,
  output logic                memreg,
  output logic [2:0]          aluop,
  output logic                retired,
  output logic                halted,
  output logic                error
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;
  localparam logic [2:0] ST_HALT   = 3'd6;
  localparam logic [2:0] ST_ERROR  = 3'd7;

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_ADDI  = 4'h1;
  localparam logic [3:0] OP_LW    = 4'h2;
  localparam logic [3:0] OP_SW    = 4'h3;
  localparam logic [3:0] OP_BEQ   = 4'h4;
  localparam logic [3:0] OP_JMP   = 4'h5;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  logic [2:0]          state;
  logic [2:0]          state_nxt;
  logic [3:0]          opcode;
  logic [CNT_W-1:0]    wait_cnt;
  logic [PC_WIDTH-1:0] br_off;

  // Branch offset is the signed imm8 field widened to the PC width.
  assign br_off = PC_WIDTH'($signed(instr[7:0]));

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_FETCH;
      ST_FETCH:  if (imem_ready) state_nxt = ST_DECODE;
      ST_DECODE: begin
        case (instr[19:16])
          OP_HALT:                               state_nxt = ST_HALT;
          OP_RTYPE, OP_ADDI, OP_LW, OP_SW,
          OP_BEQ, OP_JMP:                        state_nxt = ST_EXEC;
          default:                               state_nxt = ST_ERROR;
        endcase
      end
      ST_EXEC: begin
        case (opcode)
          OP_RTYPE, OP_ADDI: state_nxt = ST_WB;
          OP_LW, OP_SW:      state_nxt = ST_MEM;
          default:           state_nxt = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (dmem_ready)
          state_nxt = (opcode == OP_LW) ? ST_WB : ST_FETCH;
        else if (wait_cnt == CNT_LAST)
          state_nxt = ST_ERROR;
      end
      ST_WB:   state_nxt = ST_FETCH;
      default: state_nxt = state;
    endcase
  end

  // State, program counter, opcode latch and memory wait counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      pc       <= RESET_PC;
      opcode   <= 4'h0;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_FETCH && imem_ready)
        pc <= pc + PC_WIDTH'(1);
      if (state == ST_EXEC) begin
        if (opcode == OP_BEQ && zero)
          pc <= pc + br_off;
        else if (opcode == OP_JMP)
          pc <= PC_WIDTH'(instr[15:0]);
      end
      if (state == ST_DECODE)
        opcode <= instr[19:16];
      // Counter sits at zero outside MEM, so every MEM entry starts a fresh count.
      if (state == ST_MEM)
        wait_cnt <= wait_cnt + CNT_W'(1);
      else
        wait_cnt <= '0;
    end
  end

  // Output decode; held low while reset is asserted so nothing leaks before the edge.
  always_comb begin
    imem_req = 1'b0;
    ir_load  = 1'b0;
    regdst   = 1'b0;
    alusrc   = 1'b0;
    regwrite = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    memreg   = 1'b0;
    aluop    = 3'b000;
    retired  = 1'b0;
    halted   = 1'b0;
    error    = 1'b0;
    if (!reset) begin
      case (state)
        ST_FETCH: begin
          imem_req = 1'b1;
          ir_load  = imem_ready;
        end
        ST_EXEC, ST_MEM, ST_WB: begin
          aluop  = (opcode == OP_RTYPE) ? 3'b010 :
                   (opcode == OP_BEQ)   ? 3'b001 : 3'b000;
          alusrc = (opcode == OP_ADDI) || (opcode == OP_LW) || (opcode == OP_SW);
          regdst = (opcode == OP_RTYPE);
          memreg = (opcode == OP_LW);
          if (state == ST_EXEC)
            retired = (opcode == OP_BEQ) || (opcode == OP_JMP);
          if (state == ST_MEM) begin
            memread  = (opcode == OP_LW);
            memwrite = (opcode == OP_SW);
            retired  = (opcode == OP_SW) && dmem_ready;
          end
          if (state == ST_WB) begin
            regwrite = 1'b1;
            retired  = 1'b1;
          end
        end
        ST_HALT:  halted = 1'b1;
        ST_ERROR: error  = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: directed table, corner sequences, random program.
module tb_multicycle_sequencer;

  localparam int MT = 15;

  logic        clk;
  logic        reset;
  logic        start;
  logic [19:0] instr;
  logic        imem_ready;
  logic        dmem_ready;
  logic        zero;
  logic [15:0] pc;
  logic        imem_req, ir_load, regdst, alusrc, regwrite, memread, memwrite, memreg;
  logic [2:0]  aluop;
  logic        retired, halted, error;
  logic [13:0] ctrl;

  int n_cmp = 0;
  int n_bad = 0;

  multicycle_sequencer #(.PC_WIDTH(16), .RESET_PC(16'h0000), .MEM_TIMEOUT(MT)) dut (
    .clk(clk), .reset(reset), .start(start), .instr(instr),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .zero(zero),
    .pc(pc), .imem_req(imem_req), .ir_load(ir_load), .regdst(regdst),
    .alusrc(alusrc), .regwrite(regwrite), .memread(memread), .memwrite(memwrite),
    .memreg(memreg), .aluop(aluop), .retired(retired), .halted(halted), .error(error)
  );

  assign ctrl = {imem_req, ir_load, regdst, alusrc, regwrite, memread, memwrite,
                 memreg, aluop, retired, halted, error};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // end_kind: 0 retired, 1 halted, 2 error
  typedef struct {
    int          end_kind;
    int          cycles;
    int          req;
    int          ir;
    int          rd;
    int          wr;
    int          rw;
    int          ret;
    int          viol;
    logic [15:0] pc;
    logic [2:0]  aluop;
    logic        alusrc;
    logic        regdst;
    logic        memreg;
  } obs_t;

  typedef struct {
    logic [19:0] ins;
    logic        z;
    int          iw;
    int          dw;
    logic [15:0] pc;
    int          cycles;
    int          end_kind;
    int          mem;
    int          rw;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference behaviour of one instruction from the ISA timing rules.
  function automatic obs_t model(input logic [19:0] ins, input logic z, input int iw,
                                 input int dw, input logic [15:0] pc0);
    obs_t e;
    logic [15:0] pc1;
    logic [15:0] off;
    pc1 = pc0 + 16'd1;
    off = {{8{ins[7]}}, ins[7:0]};
    e = '{end_kind: 0, cycles: 0, req: iw + 1, ir: 1, rd: 0, wr: 0, rw: 0, ret: 0,
          viol: 0, pc: pc1, aluop: 3'b000, alusrc: 1'b0, regdst: 1'b0, memreg: 1'b0};
    case (ins[19:16])
      4'h0: begin e.cycles = iw + 4; e.rw = 1; e.ret = 1; e.aluop = 3'b010; e.regdst = 1'b1; end
      4'h1: begin e.cycles = iw + 4; e.rw = 1; e.ret = 1; e.alusrc = 1'b1; end
      4'h2: begin
        e.alusrc = 1'b1;
        if (dw >= MT) begin e.end_kind = 2; e.rd = MT; e.cycles = iw + 3 + MT + 1; end
        else begin e.rd = dw + 1; e.cycles = iw + 5 + dw; e.rw = 1; e.ret = 1; e.memreg = 1'b1; end
      end
      4'h3: begin
        e.alusrc = 1'b1;
        if (dw >= MT) begin e.end_kind = 2; e.wr = MT; e.cycles = iw + 3 + MT + 1; end
        else begin e.wr = dw + 1; e.cycles = iw + 4 + dw; e.ret = 1; end
      end
      4'h4: begin e.cycles = iw + 3; e.ret = 1; e.aluop = 3'b001; e.pc = z ? pc1 + off : pc1; end
      4'h5: begin e.cycles = iw + 3; e.ret = 1; e.pc = ins[15:0]; end
      4'hF: begin e.cycles = iw + 3; e.end_kind = 1; end
      default: begin e.cycles = iw + 3; e.end_kind = 2; end
    endcase
    return e;
  endfunction

  // Drive one instruction starting in FETCH; returns at the negedge after it ends.
  task automatic run_instr(input logic [19:0] ins, input logic z, input int iw,
                           input int dw, output obs_t o);
    int c = 0;
    int mseen = 0;
    int load_idx = -10;
    bit done = 0;
    o = '{end_kind: 0, cycles: 0, req: 0, ir: 0, rd: 0, wr: 0, rw: 0, ret: 0,
          viol: 0, pc: 16'h0, aluop: 3'b000, alusrc: 1'b0, regdst: 1'b0, memreg: 1'b0};
    instr = ins;
    while (!done && c < 80) begin
      c++;
      imem_ready = (c > iw);
      dmem_ready = (mseen >= dw);
      zero       = (c == load_idx + 2) ? z : 1'($urandom);
      start      = 1'($urandom);
      #1;
      if (imem_req) o.req++;
      if (ir_load) begin o.ir++; load_idx = c; end
      if (memread) o.rd++;
      if (memwrite) o.wr++;
      if (memread || memwrite) mseen++;
      if (c == load_idx + 2) begin o.aluop = aluop; o.alusrc = alusrc; end
      if (regwrite) begin o.rw++; o.regdst = regdst; o.memreg = memreg; end
      if ((memread && memwrite) || (regwrite && !retired) ||
          ((halted || error) && ((ctrl & 14'h3FFC) != 14'h0)) || (halted && error))
        o.viol++;
      if (retired) begin o.ret++; done = 1; end
      if (halted) begin o.end_kind = 1; done = 1; end
      if (error) begin o.end_kind = 2; done = 1; end
      @(negedge clk);
    end
    check("instr_done", int'(done), 1);
    o.cycles = c;
    o.pc = pc;
  endtask

  task automatic compare_all(input string tag, input obs_t a, input obs_t e);
    check({tag, "_end"},    a.end_kind,      e.end_kind);
    check({tag, "_cycles"}, a.cycles,        e.cycles);
    check({tag, "_pc"},     int'(a.pc),      int'(e.pc));
    check({tag, "_imreq"},  a.req,           e.req);
    check({tag, "_irload"}, a.ir,            e.ir);
    check({tag, "_memrd"},  a.rd,            e.rd);
    check({tag, "_memwr"},  a.wr,            e.wr);
    check({tag, "_regwr"},  a.rw,            e.rw);
    check({tag, "_retire"}, a.ret,           e.ret);
    check({tag, "_viol"},   a.viol,          e.viol);
    check({tag, "_aluop"},  int'(a.aluop),   int'(e.aluop));
    check({tag, "_alusrc"}, int'(a.alusrc),  int'(e.alusrc));
    check({tag, "_regdst"}, int'(a.regdst),  int'(e.regdst));
    check({tag, "_memreg"}, int'(a.memreg),  int'(e.memreg));
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'($urandom); imem_ready = 1'b1; dmem_ready = 1'b1;
    #1;
    check("reset_outs_pre", int'(ctrl), 0);
    @(negedge clk); #1;
    check("reset_outs", int'(ctrl), 0);
    check("reset_pc", int'(pc), 0);
    reset = 1'b0; start = 1'b0;
    @(negedge clk); #1;
    check("idle_outs", int'(ctrl), 0);
    @(negedge clk);
  endtask

  task automatic start_run();
    start = 1'b1;
    #1;
    check("idle_start_outs", int'(ctrl), 0);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Trap states must hold their flag, freeze pc and ignore start.
  task automatic hold_check(input string tag, input int n, input logic [13:0] exp_ctrl,
                            input logic [15:0] exp_pc);
    for (int i = 0; i < n; i++) begin
      start = 1'($urandom); imem_ready = 1'($urandom); dmem_ready = 1'($urandom);
      zero = 1'($urandom);
      #1;
      check({tag, "_ctrl"}, int'(ctrl), int'(exp_ctrl));
      check({tag, "_pc"}, int'(pc), int'(exp_pc));
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  vec_t vecs[15];
  obs_t o, e;
  logic [15:0] pcm;

  initial begin
    vecs[0]  = '{20'h11205, 1'b0, 0, 0,  16'h0001, 4,  0, 0,  1};
    vecs[1]  = '{20'h01230, 1'b0, 2, 0,  16'h0002, 6,  0, 0,  1};
    vecs[2]  = '{20'h21204, 1'b0, 0, 3,  16'h0003, 8,  0, 4,  1};
    vecs[3]  = '{20'h31204, 1'b0, 1, 0,  16'h0004, 5,  0, 1,  0};
    vecs[4]  = '{20'h50010, 1'b0, 0, 0,  16'h0010, 3,  0, 0,  0};
    vecs[5]  = '{20'h400FC, 1'b1, 0, 0,  16'h000D, 3,  0, 0,  0};
    vecs[6]  = '{20'h50010, 1'b1, 0, 0,  16'h0010, 3,  0, 0,  0};
    vecs[7]  = '{20'h400FC, 1'b0, 0, 0,  16'h0011, 3,  0, 0,  0};
    vecs[8]  = '{20'h5FFFF, 1'b0, 0, 0,  16'hFFFF, 3,  0, 0,  0};
    vecs[9]  = '{20'h11205, 1'b0, 0, 0,  16'h0000, 4,  0, 0,  1};
    vecs[10] = '{20'h4007F, 1'b1, 0, 0,  16'h0080, 3,  0, 0,  0};
    vecs[11] = '{20'h5FFFE, 1'b0, 0, 0,  16'hFFFE, 3,  0, 0,  0};
    vecs[12] = '{20'h40002, 1'b1, 0, 0,  16'h0001, 3,  0, 0,  0};
    vecs[13] = '{20'h21204, 1'b0, 0, 14, 16'h0002, 19, 0, 15, 1};
    vecs[14] = '{20'h31204, 1'b0, 0, 2,  16'h0003, 6,  0, 3,  0};

    reset = 1'b1; start = 1'b0; instr = 20'h0; imem_ready = 1'b0;
    dmem_ready = 1'b0; zero = 1'b0;
    @(negedge clk);
    do_reset();
    start_run();

    pcm = 16'h0000;
    for (int i = 0; i < 15; i++) begin
      run_instr(vecs[i].ins, vecs[i].z, vecs[i].iw, vecs[i].dw, o);
      check($sformatf("vec%0d_pc", i), int'(o.pc), int'(vecs[i].pc));
      check($sformatf("vec%0d_cycles", i), o.cycles, vecs[i].cycles);
      check($sformatf("vec%0d_end", i), o.end_kind, vecs[i].end_kind);
      check($sformatf("vec%0d_mem", i), o.rd + o.wr, vecs[i].mem);
      check($sformatf("vec%0d_regwr", i), o.rw, vecs[i].rw);
      e = model(vecs[i].ins, vecs[i].z, vecs[i].iw, vecs[i].dw, pcm);
      compare_all($sformatf("vec%0d", i), o, e);
      pcm = vecs[i].pc;
    end

    // SW with dmem_ready never asserted: timeout into ERROR.
    run_instr(20'h31204, 1'b0, 0, 99, o);
    check("sw_timeout_memwr", o.wr, MT);
    check("sw_timeout_end", o.end_kind, 2);
    compare_all("sw_timeout", o, model(20'h31204, 1'b0, 0, 99, pcm));
    hold_check("sw_timeout_hold", 4, 14'h0001, pcm + 16'd1);
    do_reset(); start_run();

    // Illegal opcode.
    run_instr(20'h70000, 1'b0, 0, 0, o);
    compare_all("illegal", o, model(20'h70000, 1'b0, 0, 0, 16'h0000));
    hold_check("illegal_hold", 3, 14'h0001, 16'h0001);
    do_reset(); start_run();

    // HALT with start pulses afterwards.
    run_instr(20'hF0000, 1'b0, 1, 0, o);
    compare_all("halt", o, model(20'hF0000, 1'b0, 1, 0, 16'h0000));
    hold_check("halt_hold", 6, 14'h0002, 16'h0001);
    do_reset(); start_run();

    // LW that times out exactly at the limit.
    run_instr(20'h21204, 1'b0, 0, MT, o);
    compare_all("lw_timeout", o, model(20'h21204, 1'b0, 0, MT, 16'h0000));
    do_reset(); start_run();

    // Reset asserted while an LW is waiting in MEM.
    instr = 20'h21204; imem_ready = 1'b1; dmem_ready = 1'b0; zero = 1'b0;
    repeat (4) begin #1; @(negedge clk); end
    #1;
    check("rst_mem_memread_before", int'(memread), 1);
    reset = 1'b1;
    #1;
    check("rst_mem_outs_during", int'(ctrl), 0);
    @(negedge clk);
    reset = 1'b0; dmem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("rst_mem_after%0d_ctrl", i), int'(ctrl), 0);
      check($sformatf("rst_mem_after%0d_pc", i), int'(pc), 0);
      @(negedge clk);
    end
    start_run();

    // Random program against the reference model.
    pcm = 16'h0000;
    for (int n = 0; n < 150; n++) begin
      int r;
      int op;
      int iw;
      int dw;
      logic [19:0] ins;
      logic z;
      r  = $urandom_range(0, 99);
      op = (r < 90) ? $urandom_range(0, 5) : (r < 95) ? 15 : $urandom_range(6, 14);
      ins = {4'(op), 16'($urandom)};
      z  = 1'($urandom);
      iw = $urandom_range(0, 2);
      dw = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(12, 16);
      run_instr(ins, z, iw, dw, o);
      e = model(ins, z, iw, dw, pcm);
      compare_all($sformatf("rnd%0d", n), o, e);
      if (o.end_kind != 0 || e.end_kind != 0) begin
        do_reset(); start_run();
        pcm = 16'h0000;
      end else begin
        pcm = e.pc;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
